// File: rtl/sf_stream_out_if.sv
// Bundle of the FIFO-side pop/read pins and the valid/ready stream pins for sf_stream_out.
// master is the adapter's view; slave is the view of whatever sits around it.
interface sf_stream_out_if #(
    parameter int unsigned Width    = 32,
    parameter int unsigned BufDepth = 2
);
    localparam int unsigned CntW = $clog2(BufDepth + 1);

    logic                fifo_pop_o;
    logic [Width-1:0]    fifo_q_i;
    logic                fifo_valid_i;
    logic                fifo_empty_i;
    logic                m_valid_o;
    logic [Width-1:0]    m_data_o;
    logic                m_ready_i;
    logic [CntW-1:0]     buf_count_o;
    logic                err_o;

    modport master (
        output fifo_pop_o,
        input  fifo_q_i,
        input  fifo_valid_i,
        input  fifo_empty_i,
        output m_valid_o,
        output m_data_o,
        input  m_ready_i,
        output buf_count_o,
        output err_o
    );

    modport slave (
        input  fifo_pop_o,
        output fifo_q_i,
        output fifo_valid_i,
        output fifo_empty_i,
        input  m_valid_o,
        input  m_data_o,
        output m_ready_i,
        input  buf_count_o,
        input  err_o
    );
endinterface

// File: rtl/sf_stream_out.sv
// Drains a 1-cycle-latency pop/read FIFO port into a first-word-fall-through valid/ready
// stream, using a small circular prefetch buffer so stalls never lose a popped word.
module sf_stream_out #(
    parameter int unsigned Width    = 32,
    parameter int unsigned BufDepth = 2
) (
    input  logic               fCLK,
    input  logic               fRSTn,
    sf_stream_out_if.master    bus
);
    localparam int unsigned CntW = $clog2(BufDepth + 1);
    localparam int unsigned PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int unsigned LvlW = CntW + 1;

    localparam logic [PtrW-1:0] PtrLast = PtrW'(BufDepth - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(BufDepth);
    localparam logic [LvlW-1:0] LvlMax  = LvlW'(BufDepth);

    logic [Width-1:0] mem_q [BufDepth];
    logic [Width-1:0] mem_d [BufDepth];
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             err_q, err_d;
    // Low for the first edge after reset release so a read return from a pre-reset pop is discarded.
    logic             live_q, live_d;

    logic             m_valid_c;
    logic             out_fire_c;
    logic             pop_c;
    logic             wr_req_c;
    logic             wr_en_c;
    logic             full_c;
    logic [LvlW-1:0]  level_c;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    // Next-state and pop decision
    always_comb begin
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = 1'b0;
        err_d      = err_q;
        live_d     = 1'b1;

        m_valid_c  = (count_q != '0);
        out_fire_c = m_valid_c && bus.m_ready_i;

        // Occupancy after this cycle's read, counting the word already in flight.
        level_c    = LvlW'(count_q) + LvlW'(inflight_q) - LvlW'(out_fire_c);
        pop_c      = live_q && !bus.fifo_empty_i && (level_c < LvlMax);
        inflight_d = pop_c;

        full_c     = (count_q == CntFull);
        wr_req_c   = bus.fifo_valid_i && inflight_q;
        wr_en_c    = wr_req_c && !full_c;

        if (wr_en_c) begin
            mem_d[tail_q] = bus.fifo_q_i;
            tail_d        = next_ptr(tail_q);
        end

        if (out_fire_c) begin
            head_d = next_ptr(head_q);
        end

        count_d = count_q + CntW'(wr_en_c) - CntW'(out_fire_c);

        if ((live_q && bus.fifo_valid_i && !inflight_q) || (wr_req_c && full_c)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge fCLK or negedge fRSTn) begin
        if (!fRSTn) begin
            for (int unsigned i = 0; i < BufDepth; i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            live_q     <= live_d;
        end
    end

    // Stream side is driven straight from the buffer registers.
    assign bus.fifo_pop_o  = pop_c;
    assign bus.m_valid_o   = m_valid_c;
    assign bus.m_data_o    = mem_q[head_q];
    assign bus.buf_count_o = count_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_sf_stream_out.sv
// Bench for sf_stream_out: a queue-based FIFO source with 1-cycle read latency and a
// transaction-level model of the prefetch buffer and output ordering.
module tb_sf_stream_out;
    localparam int unsigned Width    = 32;
    localparam int unsigned BufDepth = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sf_stream_out_if #(.Width(Width), .BufDepth(BufDepth)) bus ();

    sf_stream_out #(.Width(Width), .BufDepth(BufDepth)) u_dut (
        .fCLK  (clk),
        .fRSTn (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [Width-1:0] src_q[$];
    logic [Width-1:0] exp_q[$];
    logic [Width-1:0] mbuf_q[$];
    logic [Width-1:0] got_q[$];
    int               got_cyc_q[$];
    bit               model_inflight;
    int               ready_mode;
    int               cyc;
    int               n_pops;
    int               max_cnt;
    int               first_pop_cyc;
    int               first_valid_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_ready();
        case (ready_mode)
            0:       bus.m_ready_i = 1'b0;
            1:       bus.m_ready_i = 1'b1;
            default: bus.m_ready_i = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic push_word(input logic [Width-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        bus.fifo_empty_i = 1'b0;
    endtask

    task automatic clear_model();
        src_q.delete();
        exp_q.delete();
        mbuf_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        model_inflight  = 1'b0;
        cyc             = 0;
        n_pops          = 0;
        max_cnt         = 0;
        first_pop_cyc   = -1;
        first_valid_cyc = -1;
    endtask

    // One clock: check outputs at negedge against the model, advance model, drive next inputs.
    task automatic tick();
        logic             pop, mv, fire, nv;
        logic [Width-1:0] md, nq;
        int               cnt, lvl;
        bit               exp_pop;
        @(negedge clk);
        pop  = bus.fifo_pop_o;
        mv   = bus.m_valid_o;
        md   = bus.m_data_o;
        cnt  = int'(bus.buf_count_o);
        fire = (mbuf_q.size() != 0) && bus.m_ready_i;

        check("m_valid", 64'(mv), 64'(mbuf_q.size() != 0));
        if (mbuf_q.size() != 0) check("m_data", 64'(md), 64'(mbuf_q[0]));
        check("buf_count", 64'(cnt), 64'(mbuf_q.size()));
        check("err", 64'(bus.err_o), 64'(0));
        lvl     = mbuf_q.size() + int'(model_inflight) - int'(fire);
        exp_pop = (src_q.size() != 0) && (lvl < int'(BufDepth));
        check("fifo_pop", 64'(pop), 64'(exp_pop));

        if (cnt > max_cnt) max_cnt = cnt;
        if (pop && first_pop_cyc < 0) first_pop_cyc = cyc;
        if (mv && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (mv && bus.m_ready_i) begin
            got_q.push_back(md);
            got_cyc_q.push_back(cyc);
            check("order_avail", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check("order", 64'(md), 64'(exp_q.pop_front()));
        end

        if (fire) void'(mbuf_q.pop_front());
        if (bus.fifo_valid_i && model_inflight) mbuf_q.push_back(bus.fifo_q_i);
        model_inflight = pop;
        nv = 1'b0;
        nq = $urandom();
        if (pop && src_q.size() != 0) begin
            nq = src_q.pop_front();
            nv = 1'b1;
            n_pops++;
        end

        @(posedge clk);
        #1;
        cyc++;
        bus.fifo_q_i     = nq;
        bus.fifo_valid_i = nv;
        bus.fifo_empty_i = (src_q.size() == 0);
        drive_ready();
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.fifo_valid_i = 1'b0;
        bus.fifo_empty_i = 1'b1;
        bus.m_ready_i    = 1'b0;
        bus.fifo_q_i     = '0;
        ready_mode       = 0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;

        // Reset state
        do_reset();
        check("rst_pop", 64'(bus.fifo_pop_o), 64'(0));
        check("rst_valid", 64'(bus.m_valid_o), 64'(0));
        check("rst_data", 64'(bus.m_data_o), 64'(0));
        check("rst_count", 64'(bus.buf_count_o), 64'(0));
        check("rst_err", 64'(bus.err_o), 64'(0));

        // Three preloaded words, consumer always ready
        push_word(32'h11); push_word(32'h22); push_word(32'h33);
        ready_mode = 1; bus.m_ready_i = 1'b1;
        repeat (8) tick();
        check("t1_words", 64'(got_q.size()), 64'(3));
        check("t1_first_pop", 64'(first_pop_cyc), 64'(0));
        check("t1_latency", 64'(first_valid_cyc - first_pop_cyc), 64'(2));
        if (got_q.size() == 3) begin
            check("t1_w0", 64'(got_q[0]), 64'(32'h11));
            check("t1_w2", 64'(got_q[2]), 64'(32'h33));
            check("t1_first_cyc", 64'(got_cyc_q[0]), 64'(2));
            check("t1_back_to_back", 64'(got_cyc_q[2] - got_cyc_q[0]), 64'(2));
        end

        // Five words, consumer stalled: buffer fills and popping stops
        do_reset();
        for (int i = 0; i < 5; i++) push_word(32'hA0 + 32'(i));
        repeat (8) tick();
        check("t2_pops", 64'(n_pops), 64'(2));
        check("t2_count", 64'(bus.buf_count_o), 64'(2));
        check("t2_valid", 64'(bus.m_valid_o), 64'(1));
        check("t2_data", 64'(bus.m_data_o), 64'(32'hA0));
        check("t2_no_pop", 64'(bus.fifo_pop_o), 64'(0));

        // Release the stall: all five words on consecutive cycles
        got_q.delete(); got_cyc_q.delete();
        ready_mode = 1; bus.m_ready_i = 1'b1;
        repeat (10) tick();
        check("t3_words", 64'(got_q.size()), 64'(5));
        if (got_q.size() == 5) begin
            check("t3_no_bubble", 64'(got_cyc_q[4] - got_cyc_q[0]), 64'(4));
            for (int i = 0; i < 5; i++) check("t3_value", 64'(got_q[i]), 64'(32'hA0 + 32'(i)));
        end

        // Random backpressure over an incrementing 200-word source
        got_q.delete(); got_cyc_q.delete(); max_cnt = 0;
        for (int i = 0; i < 200; i++) push_word(32'(i));
        ready_mode = 2; drive_ready();
        guard = 0;
        while (got_q.size() < 200 && guard < 3000) begin
            tick();
            guard++;
        end
        check("t4_complete", 64'(got_q.size()), 64'(200));
        for (int i = 0; i < got_q.size(); i++) check("t4_seq", 64'(got_q[i]), 64'(i));
        check("t4_max_count_ok", 64'(max_cnt <= int'(BufDepth)), 64'(1));
        check("t4_err", 64'(bus.err_o), 64'(0));

        // Stray read-valid with nothing in flight
        ready_mode = 1; bus.m_ready_i = 1'b1;
        repeat (4) tick();
        bus.fifo_valid_i = 1'b1;
        bus.fifo_q_i     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.fifo_valid_i = 1'b0;
        check("t5_err_set", 64'(bus.err_o), 64'(1));
        check("t5_count", 64'(bus.buf_count_o), 64'(mbuf_q.size()));
        check("t5_valid", 64'(bus.m_valid_o), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("t5_err_sticky", 64'(bus.err_o), 64'(1));

        // Async reset mid-burst, then a late read return after release
        do_reset();
        for (int i = 0; i < 5; i++) push_word(32'hC0 + 32'(i));
        repeat (2) tick();
        check("t6_pre_count", 64'(bus.buf_count_o), 64'(1));
        check("t6_pre_inflight_valid", 64'(bus.fifo_valid_i), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_pop", 64'(bus.fifo_pop_o), 64'(0));
        check("t6_rst_valid", 64'(bus.m_valid_o), 64'(0));
        check("t6_rst_data", 64'(bus.m_data_o), 64'(0));
        check("t6_rst_count", 64'(bus.buf_count_o), 64'(0));
        check("t6_rst_err", 64'(bus.err_o), 64'(0));
        clear_model();
        bus.fifo_empty_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n            = 1'b1;
        bus.fifo_valid_i = 1'b1;
        bus.fifo_q_i     = 32'hBAD0_0BAD;
        @(posedge clk);
        #1;
        bus.fifo_valid_i = 1'b0;
        check("t6_stray_err", 64'(bus.err_o), 64'(0));
        check("t6_stray_count", 64'(bus.buf_count_o), 64'(0));
        check("t6_stray_valid", 64'(bus.m_valid_o), 64'(0));
        push_word(32'h5A); push_word(32'hA5);
        ready_mode = 1; bus.m_ready_i = 1'b1;
        repeat (6) tick();
        check("t6_resume_words", 64'(got_q.size()), 64'(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
